scr1_timer_mc: RTL and testbench



---
 rtl/scr1_timer_mc_pkg.sv | 54 +++++
 rtl/scr1_timer_mc_ch.sv | 72 +++++++
 rtl/scr1_timer_mc.sv | 180 ++++++++++++++++++
 tb/tb_scr1_timer_mc.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/scr1_timer_mc_pkg.sv
// Shared types and register map for the multi-channel machine timer.
// Optional feature macro: SCR1_TIMER_PERIODIC_EN (periodic compare auto-advance).
package scr1_timer_mc_pkg;

  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Global register offsets
  localparam int OFF_CONTROL  = 'h00;
  localparam int OFF_DIVIDER  = 'h04;
  localparam int OFF_MTIMELO  = 'h08;
  localparam int OFF_MTIMEHI  = 'h0C;
  localparam int OFF_IRQ_STS  = 'h10;
  localparam int OFF_IRQ_EN   = 'h14;

  // Channel block layout
  localparam int CH_BASE      = 'h20;
  localparam int CH_STRIDE    = 'h10;
  localparam int CH_CMPLO     = 'h0;
  localparam int CH_CMPHI     = 'h4;
  localparam int CH_PERIOD    = 'h8;
  localparam int CH_CTRL      = 'hC;

  // Control bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_RTC_BIT   = 1;
  localparam int CHCTRL_EN_BIT  = 0;
  localparam int CHCTRL_PER_BIT = 1;

  typedef struct packed {
    logic [63:0] cmp;
    logic [31:0] period;
    logic        periodic;
    logic        en;
  } type_scr1_timer_ch_s;

endpackage

// File: rtl/scr1_timer_mc_ch.sv
// One compare channel: compare register, optional periodic auto-advance, hit and pending.
// Optional feature macro: SCR1_TIMER_PERIODIC_EN.
module scr1_timer_mc_ch
  import scr1_timer_mc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [63:0]         mtime,
  input  logic [31:0]         wdata,
  input  logic                we_cmplo,
  input  logic                we_cmphi,
  input  logic                we_period,
  input  logic                we_ctrl,
  input  logic                w1c,
  output type_scr1_timer_ch_s regs,
  output logic                pending
);

  logic [63:0] cmp, cmp_wr;
  logic [31:0] period;
  logic        periodic, en;
  logic        cmp_we, hit, hit_wr, adv;

  assign cmp_we = we_cmplo | we_cmphi;
  assign cmp_wr = {we_cmphi ? wdata : cmp[63:32], we_cmplo ? wdata : cmp[31:0]};
  assign hit    = en & (mtime >= cmp);
  // a compare write re-judges the hit against the value being written
  assign hit_wr = en & (mtime >= cmp_wr);

`ifdef SCR1_TIMER_PERIODIC_EN
  // period and periodic-mode registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period   <= '0;
      periodic <= 1'b0;
    end else begin
      if (we_period) period   <= wdata;
      if (we_ctrl)   periodic <= wdata[CHCTRL_PER_BIT];
    end
  end
  assign adv = periodic & hit & (period != '0);
`else
  logic unused_per;
  assign unused_per = we_period;
  assign period     = '0;
  assign periodic   = 1'b0;
  assign adv        = 1'b0;
`endif

  // compare register: software write beats auto-advance
  always_ff @(posedge clk) begin
    if (!rst_n)      cmp <= '1;
    else if (cmp_we) cmp <= cmp_wr;
    else if (adv)    cmp <= cmp + {32'b0, period};
  end

  // channel enable
  always_ff @(posedge clk) begin
    if (!rst_n)       en <= 1'b0;
    else if (we_ctrl) en <= wdata[CHCTRL_EN_BIT];
  end

  // pending: hit dominates W1C; compare write restarts it
  always_ff @(posedge clk) begin
    if (!rst_n)      pending <= 1'b0;
    else if (cmp_we) pending <= hit_wr;
    else             pending <= (pending & ~w1c) | hit;
  end

  assign regs = '{cmp: cmp, period: period, periodic: periodic, en: en};

endmodule

// File: rtl/scr1_timer_mc.sv
// Multi-channel MMIO machine timer: mtime, prescaler, RTC sync, bus decode, channel array.
// Optional feature macro: SCR1_TIMER_PERIODIC_EN (handled in scr1_timer_mc_ch).
module scr1_timer_mc
  import scr1_timer_mc_pkg::*;
#(
  parameter int SCR1_TIMER_NCH    = 4,
  parameter int SCR1_TIMER_DIV_W  = 10,
  parameter int SCR1_TIMER_AWIDTH = 8
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rtc_in,
  input  logic                        dmem_req,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic                        dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp,
  output logic [63:0]                 timer_val,
  output logic [SCR1_TIMER_NCH-1:0]   timer_irq,
  output logic                        timer_irq_any
);

  localparam int NCH = SCR1_TIMER_NCH;
  localparam int DW  = SCR1_TIMER_DIV_W;
  localparam int AW  = SCR1_TIMER_AWIDTH;
  localparam int BW  = AW - 4;

  logic                en, clksrc_rtc;
  logic [DW-1:0]       divider, cnt;
  logic [63:0]         mtime, mtime_nxt;
  logic [NCH-1:0]      irq_en, pending;
  logic [2:0]          rtc_sync;   // [1:0] synchroniser, [2] edge register
  logic                rtc_edge, tick_en, mtime_inc;

  logic [AW-1:0]       off;
  logic [31:0]         wd, rd_val;
  logic                glb_hit, acc_ok, wr_ok;
  logic [NCH-1:0]      ch_sel;
  logic                we_ctrl, we_div, we_lo, we_hi, we_sts, we_ien;
  logic [NCH-1:0]      we_cmplo, we_cmphi, we_per, we_chctrl;
  type_scr1_timer_ch_s ch_regs [NCH];

  logic unused_addr;
  assign unused_addr = ^dmem_addr[SCR1_DMEM_AWIDTH-1:AW];

  assign off = dmem_addr[AW-1:0];
  assign wd  = dmem_wdata[31:0];

  // address decode and read mux
  always_comb begin
    glb_hit = 1'b1;
    rd_val  = '0;
    case (off)
      AW'(OFF_CONTROL): begin
        rd_val[CTRL_EN_BIT]  = en;
        rd_val[CTRL_RTC_BIT] = clksrc_rtc;
      end
      AW'(OFF_DIVIDER): rd_val = 32'(divider);
      AW'(OFF_MTIMELO): rd_val = mtime[31:0];
      AW'(OFF_MTIMEHI): rd_val = mtime[63:32];
      AW'(OFF_IRQ_STS): rd_val = 32'(pending);
      AW'(OFF_IRQ_EN):  rd_val = 32'(irq_en);
      default:          glb_hit = 1'b0;
    endcase
    for (int i = 0; i < NCH; i++) begin
      ch_sel[i] = (off[AW-1:4] == BW'(CH_BASE / CH_STRIDE + i));
      if (ch_sel[i]) begin
        case (off[3:0])
          4'(CH_CMPLO):  rd_val = ch_regs[i].cmp[31:0];
          4'(CH_CMPHI):  rd_val = ch_regs[i].cmp[63:32];
          4'(CH_PERIOD): rd_val = ch_regs[i].period;
          default: begin
            rd_val[CHCTRL_EN_BIT]  = ch_regs[i].en;
            rd_val[CHCTRL_PER_BIT] = ch_regs[i].periodic;
          end
        endcase
      end
    end
    acc_ok = (dmem_width == SCR1_MEM_WIDTH_WORD) & (off[1:0] == 2'b00) & (glb_hit | (|ch_sel));
  end

  assign wr_ok   = dmem_req & acc_ok & (dmem_cmd == SCR1_MEM_CMD_WR);
  assign we_ctrl = wr_ok & (off == AW'(OFF_CONTROL));
  assign we_div  = wr_ok & (off == AW'(OFF_DIVIDER));
  assign we_lo   = wr_ok & (off == AW'(OFF_MTIMELO));
  assign we_hi   = wr_ok & (off == AW'(OFF_MTIMEHI));
  assign we_sts  = wr_ok & (off == AW'(OFF_IRQ_STS));
  assign we_ien  = wr_ok & (off == AW'(OFF_IRQ_EN));

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign we_cmplo[i]  = wr_ok & ch_sel[i] & (off[3:0] == 4'(CH_CMPLO));
    assign we_cmphi[i]  = wr_ok & ch_sel[i] & (off[3:0] == 4'(CH_CMPHI));
    assign we_per[i]    = wr_ok & ch_sel[i] & (off[3:0] == 4'(CH_PERIOD));
    assign we_chctrl[i] = wr_ok & ch_sel[i] & (off[3:0] == 4'(CH_CTRL));

    scr1_timer_mc_ch u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .mtime     (mtime),
      .wdata     (wd),
      .we_cmplo  (we_cmplo[i]),
      .we_cmphi  (we_cmphi[i]),
      .we_period (we_per[i]),
      .we_ctrl   (we_chctrl[i]),
      .w1c       (we_sts & wd[i]),
      .regs      (ch_regs[i]),
      .pending   (pending[i])
    );
  end

  // RTC synchroniser, free-running so it never produces a spurious edge out of reset
  always_ff @(posedge clk) begin
    rtc_sync <= {rtc_sync[1:0], rtc_in};
  end
  assign rtc_edge = rtc_sync[1] ^ rtc_sync[2];

  assign tick_en   = en & (clksrc_rtc ? rtc_edge : 1'b1);
  assign mtime_inc = tick_en & (cnt == '0);

  // software writes override only the half they touch
  always_comb begin
    mtime_nxt = mtime + 64'(mtime_inc);
    if (we_lo) mtime_nxt[31:0]  = wd;
    if (we_hi) mtime_nxt[63:32] = wd;
  end

  // mtime and prescaler counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mtime <= '0;
      cnt   <= '0;
    end else begin
      mtime <= mtime_nxt;
      if (we_div)       cnt <= wd[DW-1:0];
      else if (tick_en) cnt <= (cnt == '0) ? divider : cnt - 1'b1;
    end
  end

  // control, divider and interrupt-enable registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en         <= 1'b1;
      clksrc_rtc <= 1'b0;
      divider    <= '0;
      irq_en     <= '0;
    end else begin
      if (we_ctrl) begin
        en         <= wd[CTRL_EN_BIT];
        clksrc_rtc <= wd[CTRL_RTC_BIT];
      end
      if (we_div) divider <= wd[DW-1:0];
      if (we_ien) irq_en  <= wd[NCH-1:0];
    end
  end

  // registered interrupt outputs
  always_ff @(posedge clk) begin
    if (!rst_n) timer_irq <= '0;
    else        timer_irq <= pending & irq_en;
  end
  assign timer_irq_any = |timer_irq;

  // one-cycle registered bus response
  always_ff @(posedge clk) begin
    if (!rst_n || !dmem_req) begin
      dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
      dmem_rdata <= '0;
    end else begin
      dmem_resp  <= acc_ok ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_RDY_ER;
      dmem_rdata <= (acc_ok && dmem_cmd == SCR1_MEM_CMD_RD) ? SCR1_DMEM_DWIDTH'(rd_val) : '0;
    end
  end

  assign dmem_req_ack = 1'b1;
  assign timer_val    = mtime;

endmodule

// File: tb/tb_scr1_timer_mc.sv
// Self-checking bench for scr1_timer_mc with randomized mtime/divider/RTC stimulus.
module tb_scr1_timer_mc;
  import scr1_timer_mc_pkg::*;

  localparam int NCH = 4;

  logic                 clk = 1'b0;
  logic                 rst_n, rtc_in, dmem_req;
  type_scr1_mem_cmd_e   dmem_cmd;
  type_scr1_mem_width_e dmem_width;
  logic [31:0]          dmem_addr, dmem_wdata, dmem_rdata;
  logic                 dmem_req_ack;
  type_scr1_mem_resp_e  dmem_resp;
  logic [63:0]          timer_val;
  logic [NCH-1:0]       timer_irq;
  logic                 timer_irq_any;

  int n_chk = 0, n_fail = 0;

  scr1_timer_mc #(.SCR1_TIMER_NCH(NCH), .SCR1_TIMER_DIV_W(10), .SCR1_TIMER_AWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .rtc_in(rtc_in),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .timer_val(timer_val),
    .timer_irq(timer_irq), .timer_irq_any(timer_irq_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cha(input int ch, input int r);
    return 32'(CH_BASE + CH_STRIDE * ch + r);
  endfunction

  // one bus cycle, starting and ending on a negedge
  task automatic acc(input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                     input logic [31:0] a, input logic [31:0] d,
                     output type_scr1_mem_resp_e r, output logic [31:0] q);
    dmem_req = 1'b1; dmem_cmd = c; dmem_width = w; dmem_addr = a; dmem_wdata = d;
    @(posedge clk); #1;
    r = dmem_resp; q = dmem_rdata;
    @(negedge clk);
    dmem_req = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    type_scr1_mem_resp_e r; logic [31:0] q;
    acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, a, d, r, q);
    check($sformatf("wr resp @%0h", a), r, SCR1_MEM_RESP_RDY_OK);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    type_scr1_mem_resp_e r; logic [31:0] q;
    acc(SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, a, 32'h0, r, q);
    check({tag, " resp"}, r, SCR1_MEM_RESP_RDY_OK);
    check(tag, q, exp);
  endtask

  task automatic rd_err(input type_scr1_mem_width_e w, input logic [31:0] a, input string tag);
    type_scr1_mem_resp_e r; logic [31:0] q;
    acc(SCR1_MEM_CMD_RD, w, a, 32'h0, r, q);
    check({tag, " resp"}, r, SCR1_MEM_RESP_RDY_ER);
    check({tag, " rdata"}, q, 32'h0);
  endtask

  logic [63:0] start, e;
  logic [31:0] lo, hi, cmpm, fin;
  int d, m, edges, n;
  type_scr1_mem_resp_e rr;
  logic [31:0] qq;

  initial begin
    rst_n = 1'b0; rtc_in = 1'b0; dmem_req = 1'b0;
    dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_addr = '0; dmem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst resp", dmem_resp, SCR1_MEM_RESP_NOTRDY);
    check("rst rdata", dmem_rdata, 0);
    check("rst mtime", timer_val, 0);
    check("rst irq", timer_irq, 0);
    check("rst irq_any", timer_irq_any, 0);
    check("req_ack", dmem_req_ack, 1);
    rst_n = 1'b1;

    // reset values and error responses
    rd(OFF_CONTROL, 32'h1, "ctrl reset");
    rd_err(SCR1_MEM_WIDTH_BYTE, OFF_MTIMELO, "byte rd");
    rd_err(SCR1_MEM_WIDTH_WORD, cha(NCH, 0), "ch>=NCH");
    rd_err(SCR1_MEM_WIDTH_WORD, 32'h02, "misaligned");
    rd_err(SCR1_MEM_WIDTH_WORD, 32'h18, "unmapped");
    acc(SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_HWORD, OFF_DIVIDER, 32'h7, rr, qq);
    check("hword wr resp", rr, SCR1_MEM_RESP_RDY_ER);
    rd(OFF_DIVIDER, 32'h0, "div unchanged");
    rd(cha(3, CH_CMPLO), 32'hFFFF_FFFF, "cmp reset");
    rd(OFF_IRQ_EN, 32'h0, "ien reset");
    @(posedge clk); #1;
    check("idle resp", dmem_resp, SCR1_MEM_RESP_NOTRDY);
    check("idle rdata", dmem_rdata, 0);
    @(negedge clk);

    // prescaler and mtime carry; iteration 0 is the directed LO-wrap case
    for (int it = 0; it < 5; it++) begin
      lo = (it == 0) ? 32'hFFFF_FFFF : (it == 1) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      hi = (it == 0) ? 32'h0 : $urandom;
      d  = (it == 0) ? 3 : $urandom_range(0, 5);
      m  = (it == 0) ? 3 : $urandom_range(0, 20);
      wr(OFF_CONTROL, 0); wr(OFF_MTIMELO, lo); wr(OFF_MTIMEHI, hi);
      wr(OFF_DIVIDER, d); wr(OFF_CONTROL, 1);
      start = {hi, lo};
      repeat (m) @(negedge clk);
      check("mtime val", timer_val, start + 64'(m / (d + 1)));
      e = start + 64'(m / (d + 1));       rd(OFF_MTIMELO, e[31:0],  "mtime lo");
      e = start + 64'((m + 1) / (d + 1)); rd(OFF_MTIMEHI, e[63:32], "mtime hi");
      e = start + 64'((m + 2) / (d + 1)); rd(OFF_MTIMELO, e[31:0],  "mtime lo2");
    end

    // RTC clock source: one increment per rtc_in edge, frozen when disabled
    wr(OFF_CONTROL, 0); wr(OFF_DIVIDER, 0); wr(OFF_MTIMELO, 0); wr(OFF_MTIMEHI, 0);
    wr(OFF_CONTROL, 3);
    edges = 0;
    for (int t = 0; t < 7; t++) begin
      rtc_in = ~rtc_in; edges++;
      repeat ((t < 4) ? 7 : $urandom_range(3, 10)) @(negedge clk);
      check("rtc mtime", timer_val, 64'(edges));
    end
    wr(OFF_CONTROL, 2);
    rd(OFF_CONTROL, 32'h2, "ctrl rtc");
    for (int t = 0; t < 3; t++) begin
      rtc_in = ~rtc_in;
      repeat (7) @(negedge clk);
      check("frozen mtime", timer_val, 64'(edges));
    end

    // compare hit and interrupt timing on channel 1
    wr(OFF_CONTROL, 0); wr(OFF_DIVIDER, 0); wr(OFF_MTIMELO, 90); wr(OFF_MTIMEHI, 0);
    wr(cha(1, CH_CMPLO), 100); wr(cha(1, CH_CMPHI), 0); wr(cha(1, CH_CTRL), 1);
    wr(cha(2, CH_CMPLO), 32'h1_0000); wr(cha(2, CH_CMPHI), 0); wr(cha(2, CH_CTRL), 1);
    wr(OFF_IRQ_EN, 32'hF);
    wr(OFF_CONTROL, 1);
    for (int k = 0; k < 20; k++) begin
      check("cmp mtime", timer_val, 64'(90 + k));
      check("irq vec", timer_irq, (90 + k - 2 >= 100) ? 4'b0010 : 4'b0000);
      check("irq any", timer_irq_any, (90 + k - 2 >= 100) ? 1 : 0);
      @(negedge clk);
    end
    rd(OFF_IRQ_STS, 32'h2, "sts hit");
    wr(OFF_IRQ_STS, 32'h2);
    rd(OFF_IRQ_STS, 32'h2, "w1c vs hit");
    check("irq held", timer_irq, 4'b0010);
    wr(cha(1, CH_CMPLO), 1000);
    rd(OFF_IRQ_STS, 32'h0, "cmp wr clears");
    check("irq cleared", timer_irq, 4'b0000);
    wr(cha(2, CH_CMPLO), 0);
    wr(cha(2, CH_CTRL), 0);
    rd(OFF_IRQ_STS, 32'h4, "cmp wr rehit");
    wr(OFF_IRQ_STS, 32'h4);
    rd(OFF_IRQ_STS, 32'h0, "w1c clears");
    wr(OFF_IRQ_EN, 0);

`ifdef SCR1_TIMER_PERIODIC_EN
    // periodic auto-advance on channel 0
    wr(OFF_CONTROL, 0); wr(OFF_MTIMELO, 40); wr(OFF_MTIMEHI, 0);
    wr(cha(0, CH_CMPLO), 50); wr(cha(0, CH_CMPHI), 0);
    wr(cha(0, CH_PERIOD), 20); wr(cha(0, CH_CTRL), 3);
    n = $urandom_range(50, 68);
    wr(OFF_CONTROL, 1);
    repeat (n) @(negedge clk);
    wr(OFF_CONTROL, 0);
    fin = 32'(40 + n + 1);
    rd(OFF_MTIMELO, fin, "per mtime");
    cmpm = 50;
    while (cmpm <= fin) cmpm += 20;
    rd(cha(0, CH_CMPLO), cmpm, "per cmp");
    rd(cha(0, CH_CMPHI), 0, "per cmphi");
    rd(cha(0, CH_CTRL), 3, "per chctrl");
    rd(cha(0, CH_PERIOD), 20, "per period");
    wr(cha(0, CH_CMPLO), fin - 30);
    wr(cha(0, CH_CMPLO), fin + 1000);
    rd(cha(0, CH_CMPLO), fin + 1000, "wr beats adv");
`else
    wr(cha(0, CH_PERIOD), 123);
    rd(cha(0, CH_PERIOD), 0, "period absent");
    wr(cha(0, CH_CTRL), 3);
    rd(cha(0, CH_CTRL), 1, "periodic absent");
`endif

    // reset in the middle of a read
    wr(OFF_IRQ_EN, 32'hF);
    wr(cha(3, CH_CMPLO), 0); wr(cha(3, CH_CMPHI), 0); wr(cha(3, CH_CTRL), 1);
    repeat (3) @(negedge clk);
    check("pre-rst irq3", timer_irq[3], 1);
    dmem_req = 1'b1; dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD;
    dmem_addr = OFF_CONTROL; rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst resp", dmem_resp, SCR1_MEM_RESP_NOTRDY);
    check("midrst rdata", dmem_rdata, 0);
    check("midrst mtime", timer_val, 0);
    check("midrst irq", timer_irq, 0);
    @(negedge clk);
    dmem_req = 1'b0; rst_n = 1'b1;
    rd(OFF_CONTROL, 32'h1, "post-rst ctrl");
    rd(OFF_IRQ_STS, 32'h0, "post-rst sts");
    rd(cha(3, CH_CMPLO), 32'hFFFF_FFFF, "post-rst cmp");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
